// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl: AHB-Lite slave front end for a simple dual-port block RAM.
// Port A is the byte-enabled write port and port B is the registered-address
// read port. Transfers complete with zero wait states, and illegal sizes get
// a two-cycle ERROR response.
// Optional macro AHB_BRAM_FWD_EN: a read that hits the word being written
// gets the new bytes through a forwarding merge. Without the macro, that read
// inserts one wait state so the RAM can return the committed word.
`timescale 1ns/1ps
module ahb_bram_ctrl #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic                  HWRITE,
   input  logic                  HREADY,
   input  logic [31:0]           HWDATA,
   output logic [31:0]           HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [ADDR_WIDTH-1:0] bram_addra,
   output logic [31:0]           bram_dina,
   output logic [3:0]            bram_wea,
   output logic [ADDR_WIDTH-1:0] bram_addrb,
   input  logic [31:0]           bram_doutb
);

   typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;

   state_t                state_q, state_d;
   logic                  wr_ph_q, wr_ph_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [3:0]            wr_mask_q, wr_mask_d;
   logic                  rd_ph_q, rd_ph_d;
   logic                  stall_q, stall_d;
`ifdef AHB_BRAM_FWD_EN
   logic                  fwd_hit_q, fwd_hit_d;
   logic [31:0]           fwd_data_q, fwd_data_d;
   logic [3:0]            fwd_mask_q, fwd_mask_d;
   logic [31:0]           merged;
`else
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
`endif

   logic                  illegal, acc_ok, wr_acc, rd_acc, hit;
   logic [3:0]            mask;
   logic [ADDR_WIDTH-1:0] haddr_word;
   logic                  unused_bits;

   // The upper HADDR bits alias, and the SEQ/NONSEQ distinction does not matter here.
   assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

   // Address-phase decode: byte mask, legality, and the accept qualifier.
   always_comb begin
      haddr_word = HADDR[ADDR_WIDTH+1:2];
      mask       = 4'b0000;
      case (HSIZE)
         3'd0:    mask = 4'b0001 << HADDR[1:0];
         3'd1:    mask = HADDR[1] ? 4'b1100 : 4'b0011;
         3'd2:    mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      illegal = (HSIZE >= 3'd3) || (HSIZE == 3'd1 && HADDR[0]) ||
                (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
      // No new transfer can start in ERR1 or during a stall; HREADY is low then anyway.
      acc_ok  = HSEL && HREADY && HTRANS[1] && (state_q != S_ERR1) && !stall_q;
      wr_acc  = acc_ok && !illegal && HWRITE;
      rd_acc  = acc_ok && !illegal && !HWRITE;
      // A read is hazardous when its word is the word being written in this cycle's data phase.
      hit     = wr_ph_q && (wr_addr_q == haddr_word);
   end

   // Phase flags and latched write/forwarding data for the next cycle.
   always_comb begin
      wr_ph_d   = wr_acc;
      wr_addr_d = wr_acc ? haddr_word : wr_addr_q;
      wr_mask_d = wr_acc ? mask : wr_mask_q;
`ifdef AHB_BRAM_FWD_EN
      rd_ph_d    = rd_acc;
      stall_d    = 1'b0;
      fwd_hit_d  = rd_acc && hit;
      fwd_data_d = (rd_acc && hit) ? HWDATA : fwd_data_q;
      fwd_mask_d = (rd_acc && hit) ? wr_mask_q : fwd_mask_q;
`else
      // On a hit, spend one cycle so the RAM re-reads the word after the commit.
      stall_d    = rd_acc && hit;
      rd_ph_d    = (rd_acc && !hit) || stall_q;
      rd_addr_d  = rd_acc ? haddr_word : rd_addr_q;
`endif
   end

   // Datapath registers; reset drops any pending write immediately.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wr_ph_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_mask_q  <= 4'b0000;
         rd_ph_q    <= 1'b0;
         stall_q    <= 1'b0;
`ifdef AHB_BRAM_FWD_EN
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= 32'h0;
         fwd_mask_q <= 4'b0000;
`else
         rd_addr_q  <= '0;
`endif
      end else begin
         wr_ph_q    <= wr_ph_d;
         wr_addr_q  <= wr_addr_d;
         wr_mask_q  <= wr_mask_d;
         rd_ph_q    <= rd_ph_d;
         stall_q    <= stall_d;
`ifdef AHB_BRAM_FWD_EN
         fwd_hit_q  <= fwd_hit_d;
         fwd_data_q <= fwd_data_d;
         fwd_mask_q <= fwd_mask_d;
`else
         rd_addr_q  <= rd_addr_d;
`endif
      end
   end

   // Error FSM state register.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Error FSM next state: two-cycle ERROR, re-entered from ERR2 on another illegal transfer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (acc_ok && illegal) state_d = S_ERR1;
         S_ERR1:  state_d = S_ERR2;
         S_ERR2:  state_d = (acc_ok && illegal) ? S_ERR1 : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Bus response outputs.
   always_comb begin
      HREADYOUT = (state_q != S_ERR1) && !stall_q;
      HRESP     = (state_q != S_IDLE);
   end

   // RAM ports and read data return.
   always_comb begin
      bram_addra = wr_addr_q;
      bram_dina  = HWDATA;
      bram_wea   = wr_ph_q ? wr_mask_q : 4'b0000;
`ifdef AHB_BRAM_FWD_EN
      bram_addrb = haddr_word;
      merged     = 32'h0;
      for (int i = 0; i < 4; i++)
         merged[8*i +: 8] = (fwd_hit_q && fwd_mask_q[i]) ? fwd_data_q[8*i +: 8]
                                                         : bram_doutb[8*i +: 8];
      HRDATA     = rd_ph_q ? merged : 32'h0;
`else
      bram_addrb = stall_q ? rd_addr_q : haddr_word;
      HRDATA     = rd_ph_q ? bram_doutb : 32'h0;
`endif
   end

endmodule
